// File: rtl/debounce_bank.sv
// Bank of independent switch debouncers with edge pulses and hold-to-repeat.
// Each channel is a debounce_lane; the bank only fans the vectors out.
module debounce_lane #(
  parameter int CNT_W         = 16,
  parameter int SYNC_STAGES   = 2,
  parameter bit REPEAT_EN     = 1'b1,
  parameter int RPT_W         = 24,
  parameter int REPEAT_DELAY  = 8000000,
  parameter int REPEAT_PERIOD = 2000000
) (
  input  logic clk,
  input  logic reset,
  input  logic tick,
  input  logic noisy,
  output logic clean,
  output logic rise,
  output logic fall,
  output logic rpt
);
  typedef enum logic [1:0] {IDLE, WAIT_FIRST, REPEATING} rpt_state_t;

  logic [SYNC_STAGES-1:0] sync_q;
  logic [CNT_W-1:0]       cnt_q;
  logic                   s, qualify, rise_set, clean_nxt;

  always_ff @(posedge clk) begin
    if (reset) sync_q <= '0;
    else       sync_q <= {sync_q[SYNC_STAGES-2:0], noisy};
  end
  assign s = sync_q[SYNC_STAGES-1];

  // A differing sample only flips clean once the counter has saturated on a tick.
  assign qualify   = (s != clean) && tick && (cnt_q == '1);
  assign rise_set  = qualify & s;
  assign clean_nxt = qualify ? s : clean;

  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_q <= '0;
      clean <= 1'b0;
      rise  <= 1'b0;
      fall  <= 1'b0;
    end else begin
      rise  <= rise_set;
      fall  <= qualify & ~s;
      clean <= clean_nxt;
      if (s == clean || qualify) cnt_q <= '0;
      else if (tick)             cnt_q <= cnt_q + 1'b1;
    end
  end

  generate
    if (REPEAT_EN) begin : g_rpt
      localparam logic [RPT_W-1:0] DLY_LAST = RPT_W'(REPEAT_DELAY - 1);
      localparam logic [RPT_W-1:0] PER_LAST = RPT_W'(REPEAT_PERIOD - 1);

      rpt_state_t       state_q, state_d;
      logic [RPT_W-1:0] rcnt_q, rcnt_d;
      logic             pulse_d, rpt_q;

      always_ff @(posedge clk) begin
        if (reset) begin
          state_q <= IDLE;
          rcnt_q  <= '0;
          rpt_q   <= 1'b0;
        end else begin
          state_q <= state_d;
          rcnt_q  <= rcnt_d;
          rpt_q   <= rise_set | pulse_d;
        end
      end

      // Enter WAIT_FIRST on the edge clean rises so the first repeat lands
      // exactly REPEAT_DELAY ticks after the rise pulse.
      always_comb begin
        state_d = state_q;
        rcnt_d  = rcnt_q;
        pulse_d = 1'b0;
        case (state_q)
          IDLE: if (rise_set) begin
            state_d = WAIT_FIRST;
            rcnt_d  = '0;
          end
          WAIT_FIRST: if (tick) begin
            if (rcnt_q == DLY_LAST) begin
              pulse_d = 1'b1;
              rcnt_d  = '0;
              state_d = REPEATING;
            end else rcnt_d = rcnt_q + 1'b1;
          end
          REPEATING: if (tick) begin
            if (rcnt_q == PER_LAST) begin
              pulse_d = 1'b1;
              rcnt_d  = '0;
            end else rcnt_d = rcnt_q + 1'b1;
          end
          default: state_d = IDLE;
        endcase
        // Release wins over a repeat due on the same edge.
        if (!clean_nxt) begin
          state_d = IDLE;
          rcnt_d  = '0;
          pulse_d = 1'b0;
        end
      end

      assign rpt = rpt_q;
    end else begin : g_no_rpt
      assign rpt = rise;
    end
  endgenerate
endmodule

module debounce_bank #(
  parameter int N             = 4,
  parameter int CNT_W         = 16,
  parameter int SYNC_STAGES   = 2,
  parameter bit REPEAT_EN     = 1'b1,
  parameter int RPT_W         = 24,
  parameter int REPEAT_DELAY  = 8000000,
  parameter int REPEAT_PERIOD = 2000000
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         tick,
  input  logic [N-1:0] noisy,
  output logic [N-1:0] clean,
  output logic [N-1:0] rise,
  output logic [N-1:0] fall,
  output logic [N-1:0] rpt
);
  for (genvar i = 0; i < N; i++) begin : g_lane
    debounce_lane #(
      .CNT_W(CNT_W), .SYNC_STAGES(SYNC_STAGES), .REPEAT_EN(REPEAT_EN),
      .RPT_W(RPT_W), .REPEAT_DELAY(REPEAT_DELAY), .REPEAT_PERIOD(REPEAT_PERIOD)
    ) u_lane (
      .clk  (clk),
      .reset(reset),
      .tick (tick),
      .noisy(noisy[i]),
      .clean(clean[i]),
      .rise (rise[i]),
      .fall (fall[i]),
      .rpt  (rpt[i])
    );
  end
endmodule

// File: tb/tb_debounce_bank.sv
// Directed scenarios then random bouncing, checked every cycle against a
// tick-counting reference model of the debounce/repeat rules.
module tb_debounce_bank;
  localparam int N = 4, CNT_W = 3, SYNC = 2, RPT_W = 8, DLY = 20, PER = 5;
  localparam int QUAL = 1 << CNT_W;

  logic         clk = 1'b0;
  logic         reset, tick;
  logic [N-1:0] noisy, clean, rise, fall, rpt;

  debounce_bank #(
    .N(N), .CNT_W(CNT_W), .SYNC_STAGES(SYNC), .REPEAT_EN(1'b1),
    .RPT_W(RPT_W), .REPEAT_DELAY(DLY), .REPEAT_PERIOD(PER)
  ) dut (
    .clk(clk), .reset(reset), .tick(tick), .noisy(noisy),
    .clean(clean), .rise(rise), .fall(fall), .rpt(rpt)
  );

  always #5 clk = ~clk;

  // Model: sample history, contiguous qualifying-tick run, ticks held since rise.
  logic [N-1:0] m_hist [SYNC];
  logic [N-1:0] m_clean, e_rise, e_fall, e_rpt;
  int           m_run [N];
  int           m_held [N];
  bit           m_act [N];
  int           n_cmp = 0, n_bad = 0;

  task automatic chk(input string tag, input logic [N-1:0] got, input logic [N-1:0] exp);
    n_cmp++;
    assert (got === exp) else begin
      n_bad++;
      $error("FAIL %s observed=%b expected=%b t=%0t", tag, got, exp, $time);
    end
  endtask

  task automatic chk_int(input string tag, input int got, input int exp);
    n_cmp++;
    assert (got === exp) else begin
      n_bad++;
      $error("FAIL %s observed=%0d expected=%0d t=%0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_edge();
    logic s;
    for (int i = 0; i < N; i++) begin
      if (reset) begin
        for (int k = 0; k < SYNC; k++) m_hist[k][i] = 1'b0;
        m_clean[i] = 0; e_rise[i] = 0; e_fall[i] = 0; e_rpt[i] = 0;
        m_run[i] = 0; m_held[i] = 0; m_act[i] = 0;
      end else begin
        s = m_hist[SYNC-1][i];
        for (int k = SYNC-1; k > 0; k--) m_hist[k][i] = m_hist[k-1][i];
        m_hist[0][i] = noisy[i];
        e_rise[i] = 0; e_fall[i] = 0; e_rpt[i] = 0;
        if (s == m_clean[i]) m_run[i] = 0;
        else if (tick) begin
          m_run[i]++;
          if (m_run[i] == QUAL) begin
            m_clean[i] = s; m_run[i] = 0;
            e_rise[i] = s; e_fall[i] = ~s;
          end
        end
        if (e_rise[i]) begin
          m_act[i] = 1; m_held[i] = 0; e_rpt[i] = 1;
        end else if (!m_clean[i]) begin
          m_act[i] = 0; m_held[i] = 0;
        end else if (m_act[i] && tick) begin
          m_held[i]++;
          if (m_held[i] >= DLY && (m_held[i] - DLY) % PER == 0) e_rpt[i] = 1;
        end
      end
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    model_edge();
    #1;
    chk("clean", clean, m_clean);
    chk("rise",  rise,  e_rise);
    chk("fall",  fall,  e_fall);
    chk("rpt",   rpt,   e_rpt);
  endtask

  task automatic do_reset();
    reset = 1'b1;
    cyc(); cyc();
    reset = 1'b0;
  endtask

  initial begin
    int at, np, nf, late;
    reset = 1'b1; tick = 1'b1; noisy = 4'b1010;
    for (int k = 0; k < SYNC; k++) m_hist[k] = '0;
    m_clean = '0; e_rise = '0; e_fall = '0; e_rpt = '0;
    for (int i = 0; i < N; i++) begin m_run[i] = 0; m_held[i] = 0; m_act[i] = 0; end
    cyc(); cyc();
    chk("rst_clean", clean, '0);
    chk("rst_rpt", rpt | rise | fall, '0);
    noisy = '0;
    cyc();
    reset = 1'b0;
    cyc(); cyc();

    // Single press: 10-edge latency, other channels untouched.
    noisy[0] = 1'b1; at = -1;
    for (int k = 1; k <= 15; k++) begin
      cyc();
      if (rise[0] && at < 0) begin at = k; chk("r018_rpt", rpt, 4'b0001); end
    end
    chk_int("r018_lat", at, SYNC + QUAL);
    chk("r018_others", clean & 4'b1110, '0);

    // Bounce: qualification restarts from the last rising edge.
    noisy[1] = 1'b1; for (int k = 0; k < 5; k++) cyc();
    noisy[1] = 1'b0; for (int k = 0; k < 2; k++) cyc();
    noisy[1] = 1'b1; at = -1;
    for (int k = 1; k <= 15; k++) begin
      cyc();
      if (rise[1] && at < 0) at = k;
    end
    chk_int("r019_lat", at, SYNC + QUAL);

    // Hold-to-repeat then release.
    noisy[2] = 1'b1; np = 0; nf = 0; late = 0;
    for (int k = 1; k <= 90; k++) begin
      if (k == 61) noisy[2] = 1'b0;
      cyc();
      if (rpt[2]) begin np++; if (k > 70) late++; end
      if (fall[2]) nf++;
    end
    chk_int("r020_rpts", np, 9);
    chk_int("r020_falls", nf, 1);
    chk_int("r020_late", late, 0);

    // Prescaled ticks: qualification counts strobes, not clocks.
    noisy[3] = 1'b1; at = -1;
    for (int k = 1; k <= 40; k++) begin
      tick = (k % 4 == 0);
      cyc();
      if (rise[3] && at < 0) at = k;
    end
    chk_int("r021_lat", at, 32);
    tick = 1'b1;

    // Reset in mid-qualification discards progress.
    noisy = '0;
    do_reset();
    cyc(); cyc();
    noisy[1] = 1'b1;
    for (int k = 0; k < 7; k++) cyc();
    reset = 1'b1;
    cyc();
    chk("r022_outs", clean | rise | fall | rpt, '0);
    reset = 1'b0; at = -1;
    for (int k = 1; k <= 15; k++) begin
      cyc();
      if (rise[1] && at < 0) at = k;
    end
    chk_int("r022_lat", at, SYNC + QUAL);

    // Random bouncing with random tick and occasional reset.
    for (int k = 0; k < 4000; k++) begin
      for (int i = 0; i < N; i++)
        if ($urandom_range((8 << i) - 1) == 0) noisy[i] = ~noisy[i];
      tick  = ($urandom_range(3) != 0);
      reset = ($urandom_range(799) == 0);
      cyc();
    end
    reset = 1'b0;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
